// File: rtl/tpu_pkg.sv
// Shared TPU definitions: instruction field positions, sequencer states and
// the packed program word layout used by the instruction sequencer.
package tpu_pkg;

    localparam int INSTR_W          = 5;
    localparam int HOLD_W           = 3;

    localparam int ACT_LSB          = 0;
    localparam int NN_START_BIT     = 2;
    localparam int LOAD_INPUTS_BIT  = 3;
    localparam int LOAD_WEIGHTS_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_NN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [HOLD_W-1:0]  hold;
        logic [INSTR_W-1:0] instr;
    } seq_word_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one synchronous read port.
// Contents are intentionally not reset.
module instr_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Issues a host-loaded program of instruction words to the decoder, stretching
// each by its hold count and stalling on nn_start words until nn_done.
// Optional feature macro: SEQ_LOOP_EN (adds the loop input).
module instruction_sequencer #(
    parameter int INSTR_W = tpu_pkg::INSTR_W,
    parameter int HOLD_W  = tpu_pkg::HOLD_W,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [ADDR_W-1:0]         prog_addr,
    input  logic [HOLD_W+INSTR_W-1:0] prog_wdata,
    input  logic [ADDR_W:0]           prog_len,
    input  logic                      start,
    input  logic                      nn_done,
`ifdef SEQ_LOOP_EN
    input  logic                      loop,
`endif
    output logic [INSTR_W-1:0]        instruction,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         pc
);

    import tpu_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    seq_state_t                  state;
    logic [HOLD_W-1:0]           hold_cnt;
    logic [ADDR_W:0]             len_q;
    logic [HOLD_W+INSTR_W-1:0]   rd_word;
    logic [INSTR_W-1:0]          word_instr;
    logic [HOLD_W-1:0]           word_hold;
    logic                        last_word;
    logic                        wrap;

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (HOLD_W + INSTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && (state == IDLE)),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (rd_word)
    );

    assign word_instr = rd_word[INSTR_W-1:0];
    assign word_hold  = rd_word[HOLD_W+INSTR_W-1:INSTR_W];
    assign last_word  = ({1'b0, pc} == (len_q - 1'b1));

`ifdef SEQ_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    // The read port follows pc every cycle, so the word fetched in FETCH stays
    // on rd_word for the whole ISSUE dwell; the hold counter counts up to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            hold_cnt <= '0;
            len_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        if (prog_len == '0) begin
                            state <= DONE;
                        end else begin
                            pc    <= '0;
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    hold_cnt <= '0;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (hold_cnt == word_hold) begin
                        if (word_instr[NN_START_BIT]) begin
                            state <= WAIT_NN;
                        end else if (last_word && !wrap) begin
                            state <= DONE;
                        end else begin
                            pc    <= last_word ? '0 : pc + 1'b1;
                            state <= FETCH;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_NN: begin
                    if (nn_done) begin
                        if (last_word && !wrap) begin
                            state <= DONE;
                        end else begin
                            pc    <= last_word ? '0 : pc + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign instruction = (state == ISSUE) ? word_instr : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed, table-driven bench for instruction_sequencer plus hand-written
// sequences for length clamping, reset mid-run and (with SEQ_LOOP_EN) looping.
module tb_instruction_sequencer;

    import tpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_wdata;
    logic [4:0] prog_len;
    logic       start;
    logic       nn_done;
`ifdef SEQ_LOOP_EN
    logic       loop;
`endif
    logic [4:0] instruction;
    logic       busy;
    logic       done;
    logic [3:0] pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_sequencer #(
        .INSTR_W (5),
        .HOLD_W  (3),
        .DEPTH   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .prog_len    (prog_len),
        .start       (start),
        .nn_done     (nn_done),
`ifdef SEQ_LOOP_EN
        .loop        (loop),
`endif
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [4:0]  len;
        logic        start;
        logic        nn;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [10:0] pk(logic [4:0] i, logic b, logic d, logic [3:0] p);
        return {i, b, d, p};
    endfunction

    function automatic logic [7:0] w(logic [2:0] h, logic [4:0] i);
        seq_word_t sw;
        sw.hold  = h;
        sw.instr = i;
        return sw;
    endfunction

    function automatic logic [4:0] iw(int unsigned i);
        logic [3:0] b;
        b = 4'(i);
        return {b[3], b[2], 1'b0, b[1], b[0]};
    endfunction

    function automatic vec_t mk(logic we, logic [3:0] a, logic [7:0] d, logic [4:0] len,
                                logic st, logic nn, logic [10:0] e);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.len = len;
        v.start = st; v.nn = nn; v.exp = e;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = {instruction, busy, done, pc};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got instr=%b busy=%b done=%b pc=%0d, want instr=%b busy=%b done=%b pc=%0d",
                     name, got[10:6], got[5], got[4], got[3:0], exp[10:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    initial begin
        logic [10:0] seq [10];

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        prog_len = '0; start = 1'b0; nn_done = 1'b0;
`ifdef SEQ_LOOP_EN
        loop = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        chk("reset", pk(5'b0, 1'b0, 1'b0, 4'd0));

        // two-word program, writes and start while busy, then an nn_start word
        vecs[0]  = mk(1, 0, w(0, 5'b01000), 0, 0, 0, pk(5'b00000, 0, 0, 0));
        vecs[1]  = mk(1, 1, w(2, 5'b10001), 0, 0, 0, pk(5'b00000, 0, 0, 0));
        vecs[2]  = mk(0, 0, 8'h00,          2, 1, 0, pk(5'b00000, 1, 0, 0));
        vecs[3]  = mk(0, 0, 8'h00,          2, 0, 0, pk(5'b01000, 1, 0, 0));
        vecs[4]  = mk(1, 1, w(0, 5'b00111), 0, 0, 0, pk(5'b00000, 1, 0, 1));
        vecs[5]  = mk(0, 0, 8'h00,          1, 1, 0, pk(5'b10001, 1, 0, 1));
        vecs[6]  = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b10001, 1, 0, 1));
        vecs[7]  = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b10001, 1, 0, 1));
        vecs[8]  = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b00000, 1, 1, 1));
        vecs[9]  = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b00000, 0, 0, 1));
        vecs[10] = mk(1, 0, w(1, 5'b00100), 0, 0, 0, pk(5'b00000, 0, 0, 1));
        vecs[11] = mk(0, 0, 8'h00,          1, 1, 0, pk(5'b00000, 1, 0, 0));
        vecs[12] = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b00100, 1, 0, 0));
        vecs[13] = mk(0, 0, 8'h00,          0, 0, 1, pk(5'b00100, 1, 0, 0));
        vecs[14] = mk(0, 0, 8'h00,          0, 0, 1, pk(5'b00000, 1, 0, 0));
        vecs[15] = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b00000, 1, 0, 0));
        vecs[16] = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b00000, 1, 0, 0));
        vecs[17] = mk(0, 0, 8'h00,          0, 0, 1, pk(5'b00000, 1, 1, 0));
        vecs[18] = mk(0, 0, 8'h00,          0, 0, 0, pk(5'b00000, 0, 0, 0));

        for (int i = 0; i < 19; i++) begin
            prog_we    = vecs[i].we;
            prog_addr  = vecs[i].addr;
            prog_wdata = vecs[i].wdata;
            prog_len   = vecs[i].len;
            start      = vecs[i].start;
            nn_done    = vecs[i].nn;
            step();
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end
        prog_we = 1'b0; start = 1'b0; nn_done = 1'b0;

        // zero-length program
        prog_len = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("len0_done", pk(5'b0, 1'b1, 1'b1, 4'd0));
        step();
        chk("len0_idle", pk(5'b0, 1'b0, 1'b0, 4'd0));

        // over-long length is clamped to the 16 memory entries
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = w(3'd0, iw(i));
            step();
        end
        prog_we = 1'b0;
        prog_len = 5'd20; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            logic [10:0] e;
            if (c <= 32) begin
                int k;
                k = (c - 1) / 2;
                e = (c % 2 == 1) ? pk(5'b0, 1'b1, 1'b0, 4'(k)) : pk(iw(k), 1'b1, 1'b0, 4'(k));
            end else if (c == 33) begin
                e = pk(5'b0, 1'b1, 1'b1, 4'd15);
            end else begin
                e = pk(5'b0, 1'b0, 1'b0, 4'd15);
            end
            chk($sformatf("len20_c%0d", c), e);
            step();
        end

        // reset in the middle of a hold-3 issue, then rerun
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = w(3'd3, 5'b01000);
        step();
        prog_we = 1'b0; prog_len = 5'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("rst_pre", pk(5'b01000, 1'b1, 1'b0, 4'd0));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_idle", pk(5'b0, 1'b0, 1'b0, 4'd0));
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_quiet%0d", k), pk(5'b0, 1'b0, 1'b0, 4'd0));
        end
        seq[0] = pk(5'b00000, 1, 0, 0);
        seq[1] = pk(5'b01000, 1, 0, 0);
        seq[2] = pk(5'b01000, 1, 0, 0);
        seq[3] = pk(5'b01000, 1, 0, 0);
        seq[4] = pk(5'b01000, 1, 0, 0);
        seq[5] = pk(5'b00000, 1, 1, 0);
        seq[6] = pk(5'b00000, 0, 0, 0);
        prog_len = 5'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("rerun%0d", c), seq[c]);
            step();
        end

`ifdef SEQ_LOOP_EN
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = w(3'd0, 5'b01000);
        step();
        prog_addr = 4'd1; prog_wdata = w(3'd0, 5'b10001);
        step();
        prog_we = 1'b0;
        seq[0] = pk(5'b00000, 1, 0, 0);
        seq[1] = pk(5'b01000, 1, 0, 0);
        seq[2] = pk(5'b00000, 1, 0, 1);
        seq[3] = pk(5'b10001, 1, 0, 1);
        seq[4] = pk(5'b00000, 1, 0, 0);
        seq[5] = pk(5'b01000, 1, 0, 0);
        seq[6] = pk(5'b00000, 1, 0, 1);
        seq[7] = pk(5'b10001, 1, 0, 1);
        seq[8] = pk(5'b00000, 1, 1, 1);
        seq[9] = pk(5'b00000, 0, 0, 1);
        loop = 1'b1; prog_len = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("loop%0d", c), seq[c]);
            if (c == 5) loop = 1'b0;
            step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
